// File: rtl/trisc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : trisc_pkg
// Purpose  : Shared TRISC definitions: control-word bit positions, opcode
//            encodings and the one-hot op vector seen by the controller.
// Revision : 1.0  initial release
// ============================================================================
package trisc_pkg;

  localparam int CTRL_W = 16;
  localparam int OP_W   = 11;

  // Control-word bit positions
  localparam int C_PC_CLR  = 0;   // PC <= 0
  localparam int C_PC_JMP  = 1;   // PC <= IR.addr (also steers the MAR source)
  localparam int C_PC_INC  = 2;   // PC <= PC + 1
  localparam int C_MAR_LD  = 3;   // MAR <= PC or IR.addr
  localparam int C_MEM     = 4;   // memory cycle
  localparam int C_MEM_WR  = 5;   // with C_MEM: write AC to RAM, else read into MDR
  localparam int C_SPARE6  = 6;
  localparam int C_IR_LD   = 7;   // IR <= MDR, MAR <= MDR.addr
  localparam int C_AC_CLR  = 8;   // AC <= 0
  localparam int C_AC_INC  = 9;   // AC <= AC + 1
  localparam int C_ALU_ADD = 10;  // ALU output: 0 = MDR, 1 = AC + R
  localparam int C_AC_LD   = 11;  // AC <= ALU
  localparam int C_SPARE12 = 12;
  localparam int C_SPARE13 = 13;
  localparam int C_R_LD    = 14;  // R <= MDR
  localparam int C_OUT_LD  = 15;  // out_reg <= AC (only with the output register)

  // One-hot op vector the controller branches on
  localparam logic [OP_W-1:0] OP_LDA = 11'b100_0000_0000;
  localparam logic [OP_W-1:0] OP_STA = 11'b010_0000_0000;
  localparam logic [OP_W-1:0] OP_ADD = 11'b001_0000_0000;
  localparam logic [OP_W-1:0] OP_INC = 11'b000_0010_0000;
  localparam logic [OP_W-1:0] OP_CLR = 11'b000_0001_0000;
  localparam logic [OP_W-1:0] OP_JMP = 11'b000_0000_1000;

  // 3-bit opcode field encodings
  typedef enum logic [2:0] {
    OPC_ILL0 = 3'b000,
    OPC_LDA  = 3'b001,
    OPC_STA  = 3'b010,
    OPC_ADD  = 3'b011,
    OPC_INC  = 3'b100,
    OPC_CLR  = 3'b101,
    OPC_JMP  = 3'b110,
    OPC_ILL7 = 3'b111
  } opcode_t;

  // Illegal opcodes decode to all-zero so the controller never sees a multi-hot op
  function automatic logic [OP_W-1:0] decode_op(input logic [2:0] opc);
    decode_op = '0;
    case (opcode_t'(opc))
      OPC_LDA: decode_op = OP_LDA;
      OPC_STA: decode_op = OP_STA;
      OPC_ADD: decode_op = OP_ADD;
      OPC_INC: decode_op = OP_INC;
      OPC_CLR: decode_op = OP_CLR;
      OPC_JMP: decode_op = OP_JMP;
      default: decode_op = '0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/trisc_ram.sv
`default_nettype none
// ============================================================================
// Module   : trisc_ram
// Purpose  : Single-port program/data RAM with synchronous read and write and
//            a preload port that owns the array while reset is held.
//            The registered read data is the datapath's MDR.
// Revision : 1.0  initial release
// ============================================================================
module trisc_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata;

  // Select the write source: loader while in reset, datapath otherwise
  always_comb begin
    arr_we    = en & we;
    arr_addr  = addr;
    arr_wdata = wdata;
    if (!rst_n) begin
      arr_we    = ld_we;
      arr_addr  = ld_addr;
      arr_wdata = ld_data;
    end
  end

  // Array write; contents survive reset
  always_ff @(posedge clk) begin
    if (arr_we) mem[arr_addr] <= arr_wdata;
  end

  // Registered read port (MDR), cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          rdata <= '0;
    else if (en && !we)  rdata <= mem[addr];
  end

endmodule
`default_nettype wire

// File: rtl/trisc_datapath.sv
`default_nettype none
// ============================================================================
// Module   : trisc_datapath
// Purpose  : TRISC datapath slave. Executes the 16-bit control word on PC,
//            MAR, MDR, IR, AC, R and the RAM, and decodes IR into the one-hot
//            op vector for the controller.
//            Optional feature macro: TRISC_OUTREG_EN adds out_reg loaded by C15.
// Revision : 1.0  initial release
// ============================================================================
module trisc_datapath
  import trisc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5   // must satisfy ADDR_W <= DATA_W-3
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic [CTRL_W-1:0] control,
  output logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] ac_out,
  output logic [ADDR_W-1:0] pc_out,
`ifdef TRISC_OUTREG_EN
  output logic [DATA_W-1:0] out_reg,
`endif
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] ac;
  logic [DATA_W-1:0] r;
  logic [DATA_W-1:0] alu;
  logic [ADDR_W-1:0] ir_addr;
  logic              unused_ctrl;

  assign ir_addr = ir[ADDR_W-1:0];
  assign alu     = control[C_ALU_ADD] ? (ac + r) : mdr;
  assign op      = decode_op(ir[DATA_W-1 -: 3]);
  assign ac_out  = ac;
  assign pc_out  = pc;

`ifdef TRISC_OUTREG_EN
  assign unused_ctrl = ^{control[C_SPARE6], control[C_SPARE12], control[C_SPARE13]};
`else
  assign unused_ctrl = ^{control[C_SPARE6], control[C_SPARE12], control[C_SPARE13],
                         control[C_OUT_LD]};
`endif

  // Program counter: clear beats jump beats increment
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR)                      pc <= '0;
    else if (control[C_PC_CLR])    pc <= '0;
    else if (control[C_PC_JMP])    pc <= ir_addr;
    else if (control[C_PC_INC])    pc <= pc + ADDR_W'(1);
  end

  // Memory address: IR load forwards the operand address, otherwise PC or IR.addr
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR)                      mar <= '0;
    else if (control[C_IR_LD])     mar <= mdr[ADDR_W-1:0];
    else if (control[C_MAR_LD])    mar <= control[C_PC_JMP] ? ir_addr : pc;
  end

  // Instruction register
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR)                      ir <= '0;
    else if (control[C_IR_LD])     ir <= mdr;
  end

  // Accumulator: clear beats ALU load beats increment
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR)                      ac <= '0;
    else if (control[C_AC_CLR])    ac <= '0;
    else if (control[C_AC_LD])     ac <= alu;
    else if (control[C_AC_INC])    ac <= ac + DATA_W'(1);
  end

  // ALU temp register
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR)                      r <= '0;
    else if (control[C_R_LD])      r <= mdr;
  end

`ifdef TRISC_OUTREG_EN
  // Output register snapshot of AC
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR)                      out_reg <= '0;
    else if (control[C_OUT_LD])    out_reg <= ac;
  end
`endif

  trisc_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (CLK),
    .rst_n   (CLR),
    .en      (control[C_MEM]),
    .we      (control[C_MEM_WR]),
    .addr    (mar),
    .wdata   (ac),
    .rdata   (mdr),
    .ld_we   (ld_we),
    .ld_addr (ld_addr),
    .ld_data (ld_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_trisc_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_trisc_datapath
// Purpose  : Scoreboard bench for trisc_datapath: a program of directed
//            instructions followed by random control words, each checked
//            against a register-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_trisc_datapath;

  localparam int DW = 8;
  localparam int AW = 5;
  localparam int DEPTH = 32;
  // op bit index per opcode; -1 marks an illegal opcode
  localparam int OPBIT [8] = '{-1, 10, 9, 8, 5, 4, 3, -1};

  // Control words used by the directed program
  localparam logic [15:0] W_S1   = 16'h0008;  // MAR <= PC
  localparam logic [15:0] W_RD   = 16'h0010;  // memory read
  localparam logic [15:0] W_S3   = 16'h0014;  // read + PC++
  localparam logic [15:0] W_S4   = 16'h0080;  // IR <= MDR, MAR <= addr
  localparam logic [15:0] W_LDAC = 16'h0800;  // AC <= MDR
  localparam logic [15:0] W_WR   = 16'h0030;  // RAM[MAR] <= AC
  localparam logic [15:0] W_LDR  = 16'h4000;  // R <= MDR
  localparam logic [15:0] W_ADD  = 16'h0C00;  // AC <= AC + R
  localparam logic [15:0] W_CLR  = 16'h0100;
  localparam logic [15:0] W_INC  = 16'h0200;
  localparam logic [15:0] W_JMP  = 16'h000A;  // PC <= IR.addr, MAR <= IR.addr
  localparam logic [15:0] W_ACALL= 16'h0B00;  // C8|C9|C11

  logic          CLK = 1'b0;
  logic          CLR = 1'b1;
  logic [15:0]   control = '0;
  logic [10:0]   op;
  logic [DW-1:0] ac_out;
  logic [AW-1:0] pc_out;
`ifdef TRISC_OUTREG_EN
  logic [DW-1:0] out_reg;
`endif
  logic          ld_we = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;

  trisc_datapath dut (
    .CLK     (CLK),
    .CLR     (CLR),
    .control (control),
    .op      (op),
    .ac_out  (ac_out),
    .pc_out  (pc_out),
`ifdef TRISC_OUTREG_EN
    .out_reg (out_reg),
`endif
    .ld_we   (ld_we),
    .ld_addr (ld_addr),
    .ld_data (ld_data)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [10:0]   op;
    logic [DW-1:0] ac;
    logic [AW-1:0] pc;
    logic [DW-1:0] outr;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] m_mem [DEPTH];
  logic [AW-1:0] m_pc, m_mar;
  logic [DW-1:0] m_mdr, m_ir, m_ac, m_r, m_out;

  function automatic logic [10:0] ref_op(input logic [DW-1:0] ir);
    int idx;
    int pos;
    idx = int'(ir[7:5]);
    pos = OPBIT[idx];
    if (pos < 0) return 11'd0;
    return 11'd1 << pos;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task model_reset();
    m_pc = '0; m_mar = '0; m_mdr = '0; m_ir = '0; m_ac = '0; m_r = '0; m_out = '0;
  endtask

  // All updates use the pre-edge values, then commit together
  task model_step(input logic [15:0] w);
    logic [AW-1:0] n_pc, n_mar;
    logic [DW-1:0] n_mdr, n_ir, n_ac, n_r, n_out, alu;
    n_pc = m_pc; n_mar = m_mar; n_mdr = m_mdr; n_ir = m_ir;
    n_ac = m_ac; n_r = m_r; n_out = m_out;
    if (w[0])      n_pc = 0;
    else if (w[1]) n_pc = m_ir[AW-1:0];
    else if (w[2]) n_pc = AW'((int'(m_pc) + 1) % DEPTH);
    if (w[7])      n_mar = m_mdr[AW-1:0];
    else if (w[3]) n_mar = w[1] ? m_ir[AW-1:0] : m_pc;
    if (w[4] && !w[5]) n_mdr = m_mem[m_mar];
    if (w[7]) n_ir = m_mdr;
    alu = w[10] ? DW'((int'(m_ac) + int'(m_r)) % 256) : m_mdr;
    if (w[8])       n_ac = 0;
    else if (w[11]) n_ac = alu;
    else if (w[9])  n_ac = DW'((int'(m_ac) + 1) % 256);
    if (w[14]) n_r = m_mdr;
`ifdef TRISC_OUTREG_EN
    if (w[15]) n_out = m_ac;
`endif
    if (w[4] && w[5]) m_mem[m_mar] = m_ac;
    m_pc = n_pc; m_mar = n_mar; m_mdr = n_mdr; m_ir = n_ir;
    m_ac = n_ac; m_r = n_r; m_out = n_out;
  endtask

  task push_exp();
    exp_t e;
    e.op = ref_op(m_ir); e.ac = m_ac; e.pc = m_pc; e.outr = m_out;
    sb.push_back(e);
  endtask

  task issue(input logic [15:0] w);
    @(negedge CLK);
    control = w;
    model_step(w);
    push_exp();
  endtask

  // Pulse reset inside the cycle; the edge then acts on cleared registers
  task mid_reset(input logic [15:0] w);
    @(negedge CLK);
    control = w;
    #1 CLR = 1'b0;
    model_reset();
    #2 CLR = 1'b1;
    model_step(w);
    push_exp();
  endtask

  task fetch();
    issue(W_S1); issue(W_RD); issue(W_S3); issue(W_S4);
  endtask

  task exec_lda();
    issue(W_RD); issue(W_RD); issue(W_LDAC);
  endtask

  // Monitor: one expected entry per clock edge while stimulus is active
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("op", 32'(op), 32'(e.op));
        check("ac", 32'(ac_out), 32'(e.ac));
        check("pc", 32'(pc_out), 32'(e.pc));
`ifdef TRISC_OUTREG_EN
        check("out_reg", 32'(out_reg), 32'(e.outr));
`endif
      end
    end
  end

  // Reset monitor: outputs must clear as soon as CLR falls
  initial begin
    forever begin
      @(negedge CLR);
      #1;
      check("rst_op", 32'(op), 32'd0);
      check("rst_ac", 32'(ac_out), 32'd0);
      check("rst_pc", 32'(pc_out), 32'd0);
    end
  end

  initial begin
    logic [15:0] w;
    logic [DW-1:0] prog [DEPTH];
    int wait_cyc;
    for (int i = 0; i < DEPTH; i++) prog[i] = DW'($urandom());
    prog[0]  = 8'h25; prog[1]  = 8'h2A; prog[2]  = 8'h66; prog[3]  = 8'hD4;
    prog[5]  = 8'h3C; prog[6]  = 8'h20; prog[10] = 8'hF0; prog[11] = 8'hA5;
    prog[12] = 8'hFF; prog[17] = 8'hE0; prog[18] = 8'hA0; prog[20] = 8'h2B;
    prog[21] = 8'h49; prog[22] = 8'hA0; prog[23] = 8'h29; prog[24] = 8'h2C;
    prog[25] = 8'h80; prog[26] = 8'hD1;

    #1 CLR = 1'b0;
    model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge CLK);
      ld_we = 1'b1; ld_addr = AW'(i); ld_data = prog[i];
      m_mem[i] = prog[i];
    end
    @(negedge CLK);
    ld_we = 1'b0;
    CLR = 1'b1;

    fetch(); exec_lda();                                   // LDA 5   -> 3C
    fetch(); exec_lda();                                   // LDA 10  -> F0
    fetch(); issue(W_RD); issue(W_RD); issue(W_LDR); issue(W_ADD);  // ADD 6 -> 10
    issue(W_ACALL);                                        // AC -> 0
    fetch(); issue(W_JMP);                                 // JMP 20
    issue(W_RD); issue(W_S3); issue(W_S4); exec_lda();     // LDA 11  -> A5
    fetch(); issue(W_WR); issue(W_WR);                     // STA 9
    fetch(); issue(W_CLR);                                 // CLR
    fetch(); exec_lda();                                   // LDA 9   -> A5
    fetch(); exec_lda();                                   // LDA 12  -> FF
    fetch(); issue(W_INC);                                 // INC     -> 00
    fetch(); issue(W_JMP);                                 // JMP 17
    issue(W_RD); issue(W_S3); issue(W_S4);                 // IR=E0, op=0, PC=18
    fetch(); issue(W_CLR);                                 // CLR at 18
    fetch(); issue(W_RD); mid_reset(W_RD);                 // reset mid-execute

    for (int i = 0; i < 300; i++) begin
      w = 16'($urandom());
      if ($urandom_range(0, 29) == 0) mid_reset(w);
      else issue(w);
    end

    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 20) begin
      @(posedge CLK);
      wait_cyc++;
    end
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
